mul_wb_seq: RTL
===============

# mul_wb_seq

Iterative 32x32 multiplier and register-file write-back sequencer for the multicycle core. It executes MUL, UMULL and SMULL and drives the register file's dual write port: `we3`/`wa3`/`wd3` carries the low word, and `is_mul`/`wa4`/`wd4` carries the high word. It sits between the controller, which issues `start`, and the register file, which consumes the write strobes. It replaces the single-cycle combinational multiply in the datapath.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Full product width is 2*WIDTH.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse. Sampled only in IDLE.
- `is_long` in 1: 1 = 64-bit result (UMULL/SMULL); 0 = MUL, low word only.
- `is_signed` in 1: 1 = two's-complement operands (SMULL). Ignored when `is_long`=0.
- `a` in WIDTH: multiplicand (Rm).
- `b` in WIDTH: multiplier (Rs).
- `rd_lo` in 4: destination register for the low word.
- `rd_hi` in 4: destination register for the high word.
- `busy` out 1: high in CALC, FIX and WB.
- `done` out 1: one-cycle pulse in WB.
- `we3` out 1: register-file write enable, port 3.
- `wa3` out 4: port-3 address.
- `wd3` out WIDTH: port-3 data.
- `is_mul` out 1: register-file write enable, port 4.
- `wa4` out 4: port-4 address.
- `wd4` out WIDTH: port-4 data.

## Operation
- `a`, `b`, `rd_lo`, `rd_hi`, `is_long` and `is_signed` are latched on the accepting edge. Inputs may change afterwards.
- States:
  - IDLE: waits for `start`. On `start`=1 go to CALC and clear the iteration counter.
  - CALC: radix-2 shift-add on operand magnitudes, one multiplier bit per cycle. The 2*WIDTH accumulator is unsigned, and no carry is lost. After WIDTH iterations go to FIX.
  - FIX: if signed and sign(a) XOR sign(b), negate the 64-bit product (two's complement). Otherwise pass it through. Always go to WB.
  - WB: the write-back cycle, described below. Always return to IDLE.
- Magnitudes: |x| is computed modulo 2^WIDTH. |0x80000000| = 0x80000000 is exact as unsigned. An unsigned multiply uses the raw operands.
- WB outputs:
  - `done`=1, `we3`=1, `wa3`=`rd_lo`, `wd3`=P[31:0].
  - If long: `is_mul`=1, `wa4`=`rd_hi`, `wd4`=P[63:32].
  - If MUL: `is_mul`=0.
- Outside WB, `we3`, `is_mul` and `done` are 0, and `wa3`, `wa4`, `wd3`, `wd4` are 0.
- Collision: if long and `rd_lo`==`rd_hi`, the high word wins. WB drives `wa3`=`rd_hi`, `wd3`=P[63:32] and `is_mul`=0, so only one deterministic write occurs.
- `start` while `busy`=1 (including WB) is ignored. It is not queued.
- Reset: all state, accumulator and outputs clear immediately. A reset asserted mid-operation aborts it, and no write strobe is produced.

## Timing
- Reset values: state IDLE; `busy`, `done`, `we3`, `is_mul` = 0; `wa3`, `wa4`, `wd3`, `wd4` = 0.
- Accepting edge E0 (IDLE, `start`=1): from E0, `busy`=1.
- CALC: E1..E32. FIX: E33. WB: the cycle between E33 and E34.
- The register file captures both writes at E34, and the state returns to IDLE at E34.
- Fixed latency: `done` asserts 33 cycles after E0, independent of operand values.
- Outputs are decoded from registered state and registered product, so they are glitch-free and stable for the whole WB cycle.
- Back-to-back: `start` may be asserted in the cycle after WB, giving a throughput of one operation per 35 cycles minimum.

## Test plan
- UMULL: a=0xFFFFFFFF, b=0xFFFFFFFF, rd_lo=2, rd_hi=3 -> WB: we3=1, wa3=2, wd3=0x00000001; is_mul=1, wa4=3, wd4=0xFFFFFFFE; done exactly 33 cycles after start.
- SMULL: a=0xFFFFFFFE (-2), b=3 -> wd4=0xFFFFFFFF, wd3=0xFFFFFFFA. Then a=b=0x80000000 -> wd4=0x40000000, wd3=0x00000000.
- MUL: a=7, b=6, is_long=0, is_signed=1, rd_lo=5 -> we3=1, wa3=5, wd3=42, is_mul=0. Also a=0 or b=0 -> all-zero result with unchanged latency.
- Start while busy: second `start` at E10 with different operands -> ignored; exactly one WB with the first operation's result; busy falls at E34.
- Reset mid-CALC: drop reset_n at E15 -> busy=0 and all outputs 0 immediately; no we3/is_mul pulse afterwards. A new start after release completes normally.
- Collision: SMULL a=-1, b=1, rd_lo=rd_hi=4 -> single write: we3=1, wa3=4, wd3=0xFFFFFFFF, is_mul=0.

Source files
------------

// File: rtl/mul_wb_seq.sv
// Iterative WIDTHxWIDTH multiplier with register-file write-back sequencing.
// Handles MUL (low word only), UMULL and SMULL (full 2*WIDTH product).
// The controller issues a start pulse. The low word leaves on port 3
// (we3/wa3/wd3) and the high word on port 4 (is_mul/wa4/wd4) during one
// WB cycle. The sequence is IDLE -> CALC (WIDTH cycles) -> FIX -> WB.
module mul_wb_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_long,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rd_lo,
  input  logic [3:0]       rd_hi,
  output logic             busy,
  output logic             done,
  output logic             we3,
  output logic [3:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             is_mul,
  output logic [3:0]       wa4,
  output logic [WIDTH-1:0] wd4
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;    // |a|, or raw a for an unsigned multiply
  logic [2*WIDTH-1:0] acc_reg;      // {partial high, remaining multiplier bits}
  logic [3:0]         rd_lo_reg;
  logic [3:0]         rd_hi_reg;
  logic               long_reg;
  logic               neg_reg;      // the result must be negated in FIX

  logic               sgn;
  logic [WIDTH:0]     sum;
  logic               wb;
  logic               collide;

  // Signed handling applies only to long multiplies.
  assign sgn = is_long & is_signed;

  // Add the multiplicand into the high half at full width, keeping the carry.
  always_comb begin
    sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
    if (acc_reg[0])
      sum = sum + {1'b0, mcand_reg};
  end

  // Sequencer: latch operands, then shift-add, then sign fix-up, then write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      rd_lo_reg <= '0;
      rd_hi_reg <= '0;
      long_reg  <= 1'b0;
      neg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= CALC;
            cnt_reg   <= '0;
            // The modulo-2^WIDTH magnitude of the most negative value is
            // still exact when the operand is treated as unsigned.
            mcand_reg <= (sgn && a[WIDTH-1]) ? -a : a;
            acc_reg   <= {{WIDTH{1'b0}}, ((sgn && b[WIDTH-1]) ? -b : b)};
            rd_lo_reg <= rd_lo;
            rd_hi_reg <= rd_hi;
            long_reg  <= is_long;
            neg_reg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          acc_reg <= {sum, acc_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1))
            state_reg <= FIX;
        end
        FIX: begin
          if (neg_reg)
            acc_reg <= -acc_reg;
          state_reg <= WB;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wb      = (state_reg == WB);
  assign collide = long_reg && (rd_lo_reg == rd_hi_reg);
  assign busy    = (state_reg != IDLE);

  // Write-back strobes are decoded from registered state only. When both
  // halves target the same register, only the high word is written, on port 3.
  always_comb begin
    done   = 1'b0;
    we3    = 1'b0;
    wa3    = '0;
    wd3    = '0;
    is_mul = 1'b0;
    wa4    = '0;
    wd4    = '0;
    if (wb) begin
      done = 1'b1;
      we3  = 1'b1;
      if (collide) begin
        wa3 = rd_hi_reg;
        wd3 = acc_reg[2*WIDTH-1:WIDTH];
      end else begin
        wa3 = rd_lo_reg;
        wd3 = acc_reg[WIDTH-1:0];
        if (long_reg) begin
          is_mul = 1'b1;
          wa4    = rd_hi_reg;
          wd4    = acc_reg[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule
